// File: rtl/fir_pkg.sv
// Shared constants and sizing helper for the masked FIR filter.
// Accumulator width is chosen so that the full masked sum can never overflow.
package fir_pkg;

    localparam int SHIFT_W        = 5;
    localparam int ADDR_MASK_OFS  = 0;
    localparam int ADDR_SHIFT_OFS = 1;

    function automatic int acc_w(input int data_w, input int coef_w, input int taps);
        int lg;
        lg = 0;
        while ((1 << lg) < taps) lg++;
        return data_w + coef_w + lg;
    endfunction

endpackage

// File: rtl/masked_fir_filter_if.sv
// Configuration bus plus sample/result stream of the masked FIR filter.
// The testbench or upstream logic drives master; the filter uses slave.
interface masked_fir_filter_if #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 8,
    parameter int CFG_W  = 16,
    parameter int AW     = 4
);
    logic              cfg_we;
    logic              cfg_re;
    logic [AW-1:0]     cfg_addr;
    logic [CFG_W-1:0]  cfg_wdata;
    logic [CFG_W-1:0]  cfg_rdata;
    logic              flush;
    logic              pe_n;
    logic [DATA_W-1:0] sig_in;
    logic              out_vld;
    logic [OUT_W-1:0]  out_data;
    logic              out_sat;

    modport master (
        output cfg_we, cfg_re, cfg_addr, cfg_wdata, flush, pe_n, sig_in,
        input  cfg_rdata, out_vld, out_data, out_sat
    );

    modport slave (
        input  cfg_we, cfg_re, cfg_addr, cfg_wdata, flush, pe_n, sig_in,
        output cfg_rdata, out_vld, out_data, out_sat
    );
endinterface

// File: rtl/fir_cfg_bank.sv
// Coefficient, tap-mask and shift registers with address decode and registered readback.
// A read and a write to the same address in one cycle returns the pre-write value.
module fir_cfg_bank
    import fir_pkg::*;
#(
    parameter int TAPS   = 8,
    parameter int COEF_W = 8,
    parameter int CFG_W  = 16,
    parameter int AW     = $clog2(TAPS + 2)
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic                     cfg_re,
    input  logic [AW-1:0]            cfg_addr,
    input  logic [CFG_W-1:0]         cfg_wdata,
    output logic [CFG_W-1:0]         cfg_rdata,
    output logic [TAPS*COEF_W-1:0]   coef,
    output logic [TAPS-1:0]          mask,
    output logic [SHIFT_W-1:0]       shift
);
    localparam logic [AW-1:0] ADDR_MASK  = AW'(TAPS + ADDR_MASK_OFS);
    localparam logic [AW-1:0] ADDR_SHIFT = AW'(TAPS + ADDR_SHIFT_OFS);

    logic [COEF_W-1:0]  coef_reg [TAPS];
    logic [TAPS-1:0]    mask_reg;
    logic [SHIFT_W-1:0] shift_reg;
    logic [CFG_W-1:0]   rdata_reg;
    logic [CFG_W-1:0]   rdata_next;
    logic               unused_wdata;

    assign unused_wdata = ^cfg_wdata;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) coef_reg[i] <= '0;
            mask_reg  <= '1;
            shift_reg <= '0;
        end else if (cfg_we) begin
            for (int i = 0; i < TAPS; i++)
                if (cfg_addr == AW'(i)) coef_reg[i] <= cfg_wdata[COEF_W-1:0];
            if (cfg_addr == ADDR_MASK)  mask_reg  <= cfg_wdata[TAPS-1:0];
            if (cfg_addr == ADDR_SHIFT) shift_reg <= cfg_wdata[SHIFT_W-1:0];
        end
    end

    // Unmapped addresses fall through to zero.
    always_comb begin
        rdata_next = '0;
        for (int i = 0; i < TAPS; i++)
            if (cfg_addr == AW'(i)) rdata_next = CFG_W'(coef_reg[i]);
        if (cfg_addr == ADDR_MASK)  rdata_next = CFG_W'(mask_reg);
        if (cfg_addr == ADDR_SHIFT) rdata_next = CFG_W'(shift_reg);
    end

    always_ff @(posedge clock) begin
        if (!rst_n)      rdata_reg <= '0;
        else if (cfg_re) rdata_reg <= rdata_next;
    end

    for (genvar gi = 0; gi < TAPS; gi++) begin : g_coef_flat
        assign coef[gi*COEF_W +: COEF_W] = coef_reg[gi];
    end

    assign mask      = mask_reg;
    assign shift     = shift_reg;
    assign cfg_rdata = rdata_reg;

endmodule

// File: rtl/masked_fir_filter.sv
// Streaming unsigned FIR: delay line, masked products, adder tree, round/shift/saturate.
// Sample accepted at edge t yields out_vld at edge t+3.
module masked_fir_filter
    import fir_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 8,
    parameter int OUT_W  = 8,
    parameter int CFG_W  = 16,
    parameter int AW     = $clog2(TAPS + 2)
) (
    input logic                clock,
    input logic                rst_n,
    masked_fir_filter_if.slave bus
);
    localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);
    localparam int PROD_W = DATA_W + COEF_W;

    logic [TAPS*COEF_W-1:0] coef_flat;
    logic [TAPS-1:0]        mask;
    logic [SHIFT_W-1:0]     shift;
    logic [CFG_W-1:0]       cfg_rdata;
    logic [COEF_W-1:0]      coef_unpacked [TAPS];

    fir_cfg_bank #(
        .TAPS(TAPS), .COEF_W(COEF_W), .CFG_W(CFG_W), .AW(AW)
    ) u_cfg_bank (
        .clock     (clock),
        .rst_n     (rst_n),
        .cfg_we    (bus.cfg_we),
        .cfg_re    (bus.cfg_re),
        .cfg_addr  (bus.cfg_addr),
        .cfg_wdata (bus.cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .coef      (coef_flat),
        .mask      (mask),
        .shift     (shift)
    );

    assign bus.cfg_rdata = cfg_rdata;

    for (genvar gi = 0; gi < TAPS; gi++) begin : g_coef_split
        assign coef_unpacked[gi] = coef_flat[gi*COEF_W +: COEF_W];
    end

    logic                accept;
    logic [DATA_W-1:0]   x_reg [TAPS];
    logic [COEF_W-1:0]   coef_d_reg [TAPS];
    logic [TAPS-1:0]     mask_d_reg;
    logic [SHIFT_W-1:0]  shift_d_reg, shift_s1_reg, shift_s2_reg;
    logic [PROD_W-1:0]   prod_reg [TAPS];
    logic [ACC_W-1:0]    sum_reg, sum_next;
    logic                v0_reg, v1_reg, v2_reg;
    logic                out_vld_reg, out_sat_reg;
    logic [OUT_W-1:0]    out_data_reg;

    assign accept = !bus.pe_n && !bus.flush;

    // Config copy lags the live registers by one edge, so a sample accepted on the
    // same edge as a write is multiplied by the pre-write values.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) coef_d_reg[i] <= '0;
            mask_d_reg  <= '1;
            shift_d_reg <= '0;
        end else begin
            for (int i = 0; i < TAPS; i++) coef_d_reg[i] <= coef_unpacked[i];
            mask_d_reg  <= mask;
            shift_d_reg <= shift;
        end
    end

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < TAPS; i++) sum_next = sum_next + ACC_W'(prod_reg[i]);
    end

    logic [SHIFT_W-1:0] s_eff;
    logic [ACC_W:0]     rounded;
    logic               sat_next;
    logic [OUT_W-1:0]   out_next;

    always_comb begin
        s_eff = shift_s2_reg;
        if (int'(shift_s2_reg) > ACC_W - 1) s_eff = SHIFT_W'(ACC_W - 1);
        if (s_eff == '0)
            rounded = {1'b0, sum_reg};
        else
            rounded = ({1'b0, sum_reg} + ((ACC_W + 1)'(1) << (s_eff - SHIFT_W'(1)))) >> s_eff;
        sat_next = |rounded[ACC_W:OUT_W];
        out_next = sat_next ? '1 : rounded[OUT_W-1:0];
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                x_reg[i]    <= '0;
                prod_reg[i] <= '0;
            end
            shift_s1_reg <= '0;
            shift_s2_reg <= '0;
            sum_reg      <= '0;
            v0_reg       <= 1'b0;
            v1_reg       <= 1'b0;
            v2_reg       <= 1'b0;
            out_vld_reg  <= 1'b0;
            out_data_reg <= '0;
            out_sat_reg  <= 1'b0;
        end else begin
            if (bus.flush) begin
                for (int i = 0; i < TAPS; i++) x_reg[i] <= '0;
            end else if (accept) begin
                x_reg[0] <= bus.sig_in;
                for (int i = 1; i < TAPS; i++) x_reg[i] <= x_reg[i-1];
            end
            for (int i = 0; i < TAPS; i++)
                prod_reg[i] <= mask_d_reg[i] ? PROD_W'(coef_d_reg[i]) * PROD_W'(x_reg[i]) : '0;
            shift_s1_reg <= shift_d_reg;
            shift_s2_reg <= shift_s1_reg;
            sum_reg      <= sum_next;
            v0_reg       <= accept;
            v1_reg       <= v0_reg && !bus.flush;
            v2_reg       <= v1_reg && !bus.flush;
            out_vld_reg  <= v2_reg && !bus.flush;
            if (v2_reg && !bus.flush) begin
                out_data_reg <= out_next;
                out_sat_reg  <= sat_next;
            end
        end
    end

    assign bus.out_vld  = out_vld_reg;
    assign bus.out_data = out_data_reg;
    assign bus.out_sat  = out_sat_reg;

endmodule

// File: doc/masked_fir_filter.md
# masked_fir_filter

Parametrised successor to the fixed 8-tap signal filter in the TH99CHLS datapath. It is a streaming unsigned FIR with TAPS taps, a per-tap enable mask, and a programmable rounding right-shift with saturation to OUT_W. Configuration readback is supported. The block sits between the sample input port (pe_n/sig_in) and the display formatter, and its configuration registers are driven by the CPU bus decoder.

## Interface
- DATA_W, 8: sample width, unsigned
- COEF_W, 8: coefficient width, unsigned
- TAPS, 8: number of taps, range 2..16
- OUT_W, 8: output width
- CFG_W, 16: config data width; must be ≥ max(COEF_W, TAPS, 5)
- AW, $clog2(TAPS+2): config address width
- clock  in  1  single clock, all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- cfg_we  in  1  config write strobe, one cycle
- cfg_re  in  1  config read strobe, one cycle
- cfg_addr  in  AW  address: 0..TAPS-1 = coef[k], TAPS = mask, TAPS+1 = shift
- cfg_wdata  in  CFG_W  write data, LSB-aligned
- cfg_rdata  out  CFG_W  readback data, registered
- flush  in  1  clears delay line and in-flight results
- pe_n  in  1  input valid, active-low
- sig_in  in  DATA_W  input sample
- out_vld  out  1  output valid, one cycle per result
- out_data  out  OUT_W  filtered result
- out_sat  out  1  out_data was clipped; qualified by out_vld

## Operation
- A sample is accepted on every posedge with pe_n=0 and flush=0. No backpressure; throughput is 1 sample/cycle.
- Delay line x[0..TAPS-1]: on accept, x[0]←sig_in and x[k]←x[k-1].
- Result: acc = Σ mask[k] ? coef[k]·x[k] : 0. ACC_W = DATA_W+COEF_W+$clog2(TAPS), so there is no internal overflow.
- Scaling with s = shift[4:0]: if s>0, r = (acc + 2^(s-1)) >> s (round half up); if s=0, r = acc. The shift is clamped to ACC_W-1.
- Saturation: if r > 2^OUT_W-1, out_data = all ones and out_sat=1. Otherwise out_data = r[OUT_W-1:0] and out_sat=0.
- Config writes:
  - coef[k] takes cfg_wdata[COEF_W-1:0].
  - mask takes cfg_wdata[TAPS-1:0].
  - shift takes cfg_wdata[4:0].
  - Writes to unmapped addresses are ignored.
- Config reads: on the cycle after cfg_re, cfg_rdata holds the addressed register, zero-extended. Unmapped addresses read 0. Simultaneous cfg_we and cfg_re to the same address returns the old value.
- flush: zeroes the delay line and clears all pipeline valid bits in the same cycle. A sample presented with flush is dropped. Config registers are not affected.
- Reset values:
  - coef all 0, mask all 1, shift 0, delay line 0.
  - out_vld 0, out_data 0, out_sat 0, cfg_rdata 0.
  - All pipeline valid bits 0.

## Timing
- Pipeline stages:
  - S0: accept into the delay line.
  - S1: masked products registered.
  - S2: adder tree sum registered.
  - S3: round, shift and saturate registered to the outputs.
- Latency: a sample accepted at edge t produces out_vld=1 at edge t+3. Back-to-back samples give back-to-back results.
- Coherence: a config write at edge t affects results for samples accepted at edge ≥ t+1. A sample accepted at the same edge as the write uses the old value.
- Reset mid-stream: all in-flight results are discarded and no out_vld is asserted after the reset edge.
- pe_n gaps: the delay line holds its value, and out_vld is low for the corresponding cycles.

## Structure
- Package fir_pkg holds:
  - function acc_w(DATA_W, COEF_W, TAPS);
  - localparam address offsets ADDR_MASK_OFS = 0 and ADDR_SHIFT_OFS = 1, both relative to TAPS;
  - SHIFT_W = 5.
- One sub-module, fir_cfg_bank, contains the coefficient, mask and shift registers with write decode and registered readback. It exports flat coef, mask and shift vectors.
- The top level contains the delay line, product stage, adder tree and scaler.

## Test plan
- Basic filter: TAPS=8; coef[0..3]=1,2,3,0; mask=0x0F; shift=2; samples 65,66,67,68 back-to-back. Required: out_data=16,49,99,100 at edges +3..+6; out_sat=0.
- Saturation: same setup with shift=0. Required: outputs 65,196,255 (out_sat=1), then 255 (out_sat=1).
- Readback: write coef[5]=0xA7 and mask=0x00F0, read both back, then read address TAPS+2. Required: 0x00A7, 0x00F0, 0x0000, each one cycle after cfg_re.
- Coherence and masking: stream constant 10. Write mask=0x01 at the same edge as sample n. Required: sample n still uses the old mask; samples from n+1 produce exactly coef[0]·10 (rounded and shifted).
- Flush: stream 3 samples, assert flush one cycle while a 4th sample is presented. Required: no out_vld for the in-flight or dropped samples. The next sample 5 with coef[0]=1, mask=0x01, shift=0 gives 5.
- Reset mid-stream: assert rst_n=0 for one edge during streaming. Required: outputs 0, coef 0, mask all ones, and no stale out_vld afterwards.
